muxcont_rr_lock: RTL and testbench
==================================

// Module: muxcont_rr_lock
// PURPOSE
//  Parametrised output-port mux controller for the router crossbar: one instance per output port.
//  Arbitrates NPORT input channels with rotating round-robin and multicast/absorb priority.
//  Holds a wormhole lock from head to tail flit; anti-starvation aging for unicast traffic.
//  Drives one-hot grant back to inputs and a registered one-hot select to the crossbar mux.
// PARAMETERS
//  NPORT    5   number of input channels arbitrated
//  PORTW    3   width of per-input destination port field
//  PORTID   0   output port index served by this instance
//  AGE_MAX  8   consecutive unicast-losing arbitrations before multicast priority is suppressed
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst        in   1            synchronous reset, active-high
//  req_i      in   NPORT        per-input flit valid
//  dst_i      in   NPORT*PORTW  per-input destination port; slice i = dst_i[i*PORTW +: PORTW]
//  mc_i       in   NPORT        per-input multicast/absorb flag (eligible regardless of dst)
//  tail_i     in   NPORT        per-input flit is tail (head+tail = single-flit packet)
//  ready_i    in   1            downstream accepts a flit this cycle
//  grt_o      out  NPORT        one-hot grant, combinational from state and inputs
//  sel_o      out  NPORT        registered one-hot crossbar select (input transferred last cycle)
//  busy_o     out  1            lock held (state LOCKED)
//  mc_ct_o    out  NPORT        multicast contention: req_i & mc_i & ~grt_o, per bit
// BEHAVIOUR
//  - eligible[i] = req_i[i] & (mc_i[i] | dst_i[i]==PORTID).
//  - mcmask = eligible & mc_i; if |mcmask and age<AGE_MAX, candidates = mcmask, else candidates = eligible.
//  - Round-robin: search candidates starting at ptr+1 mod NPORT, wrapping; first hit wins.
//  - xfer = |(grt_o & req_i) & ready_i. Grant may be asserted while ready_i=0; no transfer, no state change.
//  - FSM IDLE: grt_o = one-hot winner (0 if no candidate).
//      xfer & tail_i[win]: stay IDLE, ptr<=win.  xfer & ~tail: ->LOCKED, owner<=win.
//      no xfer: stay IDLE, ptr unchanged (winner recomputed next cycle).
//  - FSM LOCKED: grt_o = onehot(owner) & req_i; all other inputs, including multicast, get 0.
//      owner req_i low (bubble): stay LOCKED, grt_o=0. xfer & tail_i[owner]: ->IDLE, ptr<=owner.
//  - Aging: age (width clog2(AGE_MAX+1)) increments, saturating at AGE_MAX, on each IDLE xfer granted to
//    an mc input while some eligible non-mc input existed; clears to 0 on any xfer granted to a non-mc input.
//  - sel_o <= grt_o when xfer, else 0. One cycle after each transfer, exactly one bit set.
//  - Reset: state=IDLE, ptr=NPORT-1 (input 0 highest priority first), owner=0, age=0, sel_o=0;
//    grt_o=0 and busy_o=0 during reset cycle. Reset mid-packet drops lock unconditionally.
//  - grt_o always zero- or one-hot; never grants an input with req_i low.
// TESTING
//  1 Inputs 1,3 unicast to PORTID, single-flit, ready=1 x4 -> grants 1,3,1,3; sel_o lags grt by 1.
//  2 In0 head,body,tail w/ ready toggling 1,0,1,1; in2 requests throughout -> grt_o=0b00001 until
//    tail xfer, busy_o high 3 cycles, then grt_o=0b00100.
//  3 In4 mc single-flits, in1 unicast, AGE_MAX=8 -> 8 grants to in4 (mc_ct_o[1]=0, age counts),
//    9th grant to in1, age clears, mc priority resumes.
//  4 In2 dst!=PORTID, mc=0, req=1 -> never granted; with mc=1 -> granted.
//  5 Assert rst while LOCKED on in3 -> next cycle busy_o=0, sel_o=0, ptr=NPORT-1; in0 wins over in3.
//  6 Owner drops req mid-packet 2 cycles while in1 requests -> grt_o=0, lock held, in1 not granted.

Source files
------------

// File: rtl/muxcont_rr_lock_if.sv
`default_nettype none
// ============================================================================
// Module   : muxcont_rr_lock_if
// Brief    : Handshake bundle between the input channels / downstream port
//            and one output-port mux controller of the router crossbar.
// Revision : 1.0  initial release
// ============================================================================
interface muxcont_rr_lock_if #(
  parameter int NPORT = 5,
  parameter int PORTW = 3
);

  // Input-channel side: per-input flit presentation
  logic [NPORT-1:0]       req_i;
  logic [NPORT*PORTW-1:0] dst_i;
  logic [NPORT-1:0]       mc_i;
  logic [NPORT-1:0]       tail_i;
  // Downstream flow control
  logic                   ready_i;
  // Controller results
  logic [NPORT-1:0]       grt_o;
  logic [NPORT-1:0]       sel_o;
  logic                   busy_o;
  logic [NPORT-1:0]       mc_ct_o;

  // Driver of the channels (router / testbench)
  modport master (
    output req_i, dst_i, mc_i, tail_i, ready_i,
    input  grt_o, sel_o, busy_o, mc_ct_o
  );

  // The mux controller itself
  modport slave (
    input  req_i, dst_i, mc_i, tail_i, ready_i,
    output grt_o, sel_o, busy_o, mc_ct_o
  );

endinterface
`default_nettype wire

// File: rtl/muxcont_rr_lock.sv
`default_nettype none
// ============================================================================
// Module   : muxcont_rr_lock
// Brief    : Output-port mux controller. Round-robin arbitration over NPORT
//            inputs with multicast/absorb priority, wormhole lock from head
//            to tail flit, and aging that lets starved unicast traffic past
//            a stream of multicast winners. Drives a combinational one-hot
//            grant and a registered one-hot crossbar select.
// Revision : 1.0  initial release
// ============================================================================
module muxcont_rr_lock #(
  parameter int NPORT   = 5,
  parameter int PORTW   = 3,
  parameter int PORTID  = 0,
  parameter int AGE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  muxcont_rr_lock_if.slave   bus
);

  localparam int c_ptr_w = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int c_age_w = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(NPORT - 1);
  localparam logic [c_age_w-1:0] c_age_max  = c_age_w'(AGE_MAX);
  localparam logic [PORTW-1:0]   c_port_id  = PORTW'(PORTID);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic [c_ptr_w-1:0] r_ptr;     // last input served; search starts one past it
  logic [c_ptr_w-1:0] r_owner;   // input holding the wormhole lock
  logic [c_age_w-1:0] r_age;     // multicast wins over waiting unicast traffic
  logic [NPORT-1:0]   r_sel;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [NPORT-1:0]   w_elig;
  logic [NPORT-1:0]   w_mcmask;
  logic [NPORT-1:0]   w_cand;
  logic               w_mc_pri;
  logic               w_nonmc_wait;
  logic [c_ptr_w-1:0] w_scan;
  logic               w_win_found;
  logic [c_ptr_w-1:0] w_win_idx;
  logic [NPORT-1:0]   w_win_oh;
  logic [NPORT-1:0]   w_owner_oh;
  logic [NPORT-1:0]   w_grt;
  logic [c_ptr_w-1:0] w_gidx;
  logic               w_xfer;
  logic               w_g_tail;
  logic               w_g_mc;
  logic               w_age_inc;

  // Wrap-around successor of an input index
  function automatic logic [c_ptr_w-1:0] next_idx(input logic [c_ptr_w-1:0] p);
    if (p == c_ptr_last) begin
      return '0;
    end
    return p + c_ptr_w'(1);
  endfunction

  // Per-input eligibility and one-hot decodes of owner and winner
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign w_elig[gi]     = bus.req_i[gi] &
                            (bus.mc_i[gi] | (bus.dst_i[gi*PORTW +: PORTW] == c_port_id));
    assign w_owner_oh[gi] = (r_owner == c_ptr_w'(gi));
    assign w_win_oh[gi]   = w_win_found & (w_win_idx == c_ptr_w'(gi));
  end

  // Multicast candidates take precedence unless unicast has aged out
  assign w_mcmask     = w_elig & bus.mc_i;
  assign w_nonmc_wait = |(w_elig & ~bus.mc_i);
  assign w_mc_pri     = (|w_mcmask) & (r_age < c_age_max);
  assign w_cand       = w_mc_pri ? w_mcmask : w_elig;

  // Round-robin search: first candidate at or after ptr+1, wrapping
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_ptr;
    w_scan      = r_ptr;
    for (int k = 0; k < NPORT; k++) begin
      w_scan = next_idx(w_scan);
      if (!w_win_found && w_cand[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
    end
  end

  // Grant: arbitration winner when idle, only the requesting owner when locked
  always_comb begin
    w_grt = '0;
    if (!rst) begin
      if (r_state == ST_IDLE) begin
        w_grt = w_win_oh;
      end else begin
        w_grt = w_owner_oh & bus.req_i;
      end
    end
  end

  assign w_gidx    = (r_state == ST_LOCKED) ? r_owner : w_win_idx;
  assign w_xfer    = (|(w_grt & bus.req_i)) & bus.ready_i;
  assign w_g_tail  = bus.tail_i[w_gidx];
  assign w_g_mc    = bus.mc_i[w_gidx];
  // Age only counts multicast wins taken at arbitration while unicast waited
  assign w_age_inc = (r_state == ST_IDLE) & w_g_mc & w_nonmc_wait & (r_age < c_age_max);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.grt_o   = w_grt;
  assign bus.sel_o   = r_sel;
  assign bus.busy_o  = (r_state == ST_LOCKED) & ~rst;
  assign bus.mc_ct_o = bus.req_i & bus.mc_i & ~w_grt;

  // Lock FSM, round-robin pointer, aging counter and crossbar select
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= c_ptr_last;
      r_owner <= '0;
      r_age   <= '0;
      r_sel   <= '0;
    end else begin
      r_sel <= w_xfer ? w_grt : '0;

      if (w_xfer) begin
        if (!w_g_mc) begin
          r_age <= '0;
        end else if (w_age_inc) begin
          r_age <= r_age + c_age_w'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_g_tail) begin
              r_ptr <= w_win_idx;
            end else begin
              r_state <= ST_LOCKED;
              r_owner <= w_win_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_g_tail) begin
            r_state <= ST_IDLE;
            r_ptr   <= r_owner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Structural invariants
  // --------------------------------------------------------------------------
  a_grt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_grt));
  a_grt_req:    assert property (@(posedge clk) disable iff (rst) (w_grt & ~bus.req_i) == '0);
  a_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_sel));

endmodule
`default_nettype wire

// File: tb/tb_muxcont_rr_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxcont_rr_lock
// Brief    : Self-checking bench for muxcont_rr_lock: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_muxcont_rr_lock;

  localparam int NPORT   = 5;
  localparam int PORTW   = 3;
  localparam int PORTID  = 0;
  localparam int AGE_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muxcont_rr_lock_if #(.NPORT(NPORT), .PORTW(PORTW)) bus ();

  muxcont_rr_lock #(
    .NPORT  (NPORT),
    .PORTW  (PORTW),
    .PORTID (PORTID),
    .AGE_MAX(AGE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  bit               m_locked = 1'b0;
  int               m_ptr    = NPORT - 1;
  int               m_owner  = 0;
  int               m_age    = 0;
  logic [NPORT-1:0] m_sel    = '0;

  logic [NPORT-1:0] t1_grt [4] = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.req_i   = '0;
    bus.dst_i   = '0;
    bus.mc_i    = '0;
    bus.tail_i  = '0;
    bus.ready_i = 1'b0;
  endtask

  task automatic put(input int p, input int d, input bit m, input bit t);
    bus.req_i[p]                = 1'b1;
    bus.dst_i[p*PORTW +: PORTW] = PORTW'(d);
    bus.mc_i[p]                 = m;
    bus.tail_i[p]               = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    step();
    rst = 1'b0;
  endtask

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    logic [NPORT-1:0] e_grt;
    logic [NPORT-1:0] elig;
    logic [NPORT-1:0] mcm;
    logic [NPORT-1:0] cand;
    int               win;
    bit               xfer;
    bit               any_nonmc;
    if (chk_en) begin
      e_grt     = '0;
      elig      = '0;
      mcm       = '0;
      win       = -1;
      any_nonmc = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        elig[i] = bus.req_i[i] && (bus.mc_i[i] || int'(bus.dst_i[i*PORTW +: PORTW]) == PORTID);
        if (elig[i] && bus.mc_i[i])  mcm[i] = 1'b1;
        if (elig[i] && !bus.mc_i[i]) any_nonmc = 1'b1;
      end
      if (rst) begin
        check("model grt(rst)",   32'(bus.grt_o),   32'(0));
        check("model busy(rst)",  32'(bus.busy_o),  32'(0));
        check("model mc_ct(rst)", 32'(bus.mc_ct_o), 32'(bus.req_i & bus.mc_i));
        check("model sel(rst)",   32'(bus.sel_o),   32'(m_sel));
        m_locked = 1'b0;
        m_ptr    = NPORT - 1;
        m_owner  = 0;
        m_age    = 0;
        m_sel    = '0;
      end else begin
        if (!m_locked) begin
          cand = (mcm != '0 && m_age < AGE_MAX) ? mcm : elig;
          for (int k = 1; k <= NPORT; k++) begin
            if (win < 0 && cand[(m_ptr + k) % NPORT]) win = (m_ptr + k) % NPORT;
          end
        end else if (bus.req_i[m_owner]) begin
          win = m_owner;
        end
        if (win >= 0) e_grt[win] = 1'b1;
        xfer = (win >= 0) && bus.ready_i;
        check("model grt",   32'(bus.grt_o),   32'(e_grt));
        check("model busy",  32'(bus.busy_o),  32'(m_locked));
        check("model sel",   32'(bus.sel_o),   32'(m_sel));
        check("model mc_ct", 32'(bus.mc_ct_o), 32'(bus.req_i & bus.mc_i & ~e_grt));
        m_sel = xfer ? e_grt : '0;
        if (xfer) begin
          if (!bus.mc_i[win]) m_age = 0;
          else if (!m_locked && any_nonmc && m_age < AGE_MAX) m_age++;
          if (!m_locked) begin
            if (bus.tail_i[win]) m_ptr = win;
            else begin
              m_locked = 1'b1;
              m_owner  = win;
            end
          end else if (bus.tail_i[win]) begin
            m_locked = 1'b0;
            m_ptr    = win;
          end
        end
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset grt",  32'(bus.grt_o),  32'(0));
    check("reset busy", 32'(bus.busy_o), 32'(0));
    check("reset sel",  32'(bus.sel_o),  32'(0));
    step();
    rst = 1'b0;

    // 1: two unicast single-flit inputs alternate, select lags grant
    do_reset();
    put(1, PORTID, 1'b0, 1'b1);
    put(3, PORTID, 1'b0, 1'b1);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1 grt", 32'(bus.grt_o), 32'(t1_grt[i]));
      check("t1 sel", 32'(bus.sel_o), (i == 0) ? 32'(0) : 32'(t1_grt[i-1]));
      step();
    end

    // 2: three-flit packet on in0 with ready stall, in2 waits
    do_reset();
    put(0, PORTID, 1'b0, 1'b0);
    put(2, PORTID, 1'b0, 1'b1);
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("t2 head grt",  32'(bus.grt_o),  32'h01);
    check("t2 head busy", 32'(bus.busy_o), 32'(0));
    step();
    bus.ready_i = 1'b0;
    @(negedge clk);
    check("t2 stall grt",  32'(bus.grt_o),  32'h01);
    check("t2 stall busy", 32'(bus.busy_o), 32'(1));
    check("t2 stall sel",  32'(bus.sel_o),  32'h01);
    step();
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("t2 body grt",  32'(bus.grt_o),  32'h01);
    check("t2 body sel",  32'(bus.sel_o),  32'(0));
    step();
    bus.tail_i[0] = 1'b1;
    @(negedge clk);
    check("t2 tail grt",  32'(bus.grt_o),  32'h01);
    check("t2 tail busy", 32'(bus.busy_o), 32'(1));
    step();
    bus.req_i[0] = 1'b0;
    @(negedge clk);
    check("t2 next grt",  32'(bus.grt_o),  32'h04);
    check("t2 next busy", 32'(bus.busy_o), 32'(0));
    check("t2 next sel",  32'(bus.sel_o),  32'h01);
    step();

    // 3: multicast priority until unicast ages out
    do_reset();
    put(4, 3, 1'b1, 1'b1);
    put(1, PORTID, 1'b0, 1'b1);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3 grt",   32'(bus.grt_o),   (i == 8) ? 32'h02 : 32'h10);
      check("t3 mc_ct", 32'(bus.mc_ct_o), (i == 8) ? 32'h10 : 32'h00);
      step();
    end

    // 4: non-matching unicast is never granted, multicast is
    do_reset();
    put(2, 1, 1'b0, 1'b1);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4 foreign grt", 32'(bus.grt_o), 32'(0));
      step();
    end
    bus.mc_i[2] = 1'b1;
    @(negedge clk);
    check("t4 mc grt", 32'(bus.grt_o), 32'h04);
    step();

    // 5: reset while locked drops the lock and restores priority
    do_reset();
    put(3, PORTID, 1'b0, 1'b0);
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("t5 head grt", 32'(bus.grt_o), 32'h08);
    step();
    @(negedge clk);
    check("t5 locked busy", 32'(bus.busy_o), 32'(1));
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5 rst grt",  32'(bus.grt_o),  32'(0));
    check("t5 rst busy", 32'(bus.busy_o), 32'(0));
    step();
    rst = 1'b0;
    put(0, PORTID, 1'b0, 1'b1);
    @(negedge clk);
    check("t5 after busy", 32'(bus.busy_o), 32'(0));
    check("t5 after sel",  32'(bus.sel_o),  32'(0));
    check("t5 after grt",  32'(bus.grt_o),  32'h01);
    step();

    // 6: owner bubbles keep the lock and block other inputs
    do_reset();
    put(0, PORTID, 1'b0, 1'b0);
    put(1, PORTID, 1'b0, 1'b1);
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("t6 head grt", 32'(bus.grt_o), 32'h01);
    step();
    bus.req_i[0] = 1'b0;
    @(negedge clk);
    check("t6 bubble1 grt",  32'(bus.grt_o),  32'(0));
    check("t6 bubble1 busy", 32'(bus.busy_o), 32'(1));
    check("t6 bubble1 sel",  32'(bus.sel_o),  32'h01);
    step();
    @(negedge clk);
    check("t6 bubble2 grt",  32'(bus.grt_o),  32'(0));
    check("t6 bubble2 sel",  32'(bus.sel_o),  32'(0));
    step();
    bus.req_i[0]  = 1'b1;
    bus.tail_i[0] = 1'b1;
    @(negedge clk);
    check("t6 tail grt", 32'(bus.grt_o), 32'h01);
    step();
    bus.req_i[0] = 1'b0;
    @(negedge clk);
    check("t6 next grt",  32'(bus.grt_o),  32'h02);
    check("t6 next busy", 32'(bus.busy_o), 32'(0));
    step();

    // Randomized traffic, checked every cycle by the reference model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int p = 0; p < NPORT; p++) begin
        bus.req_i[p]                = ($urandom_range(0, 9) < 6);
        bus.dst_i[p*PORTW +: PORTW] = ($urandom_range(0, 1) == 0) ? PORTW'(PORTID)
                                                                   : PORTW'($urandom_range(0, 7));
        bus.mc_i[p]                 = ($urandom_range(0, 3) == 0);
        bus.tail_i[p]               = ($urandom_range(0, 1) == 0);
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    clr();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
